// File: rtl/cmn_fifo_vr.sv
// Valid/ready FIFO with a registered first-word-fall-through output stage, occupancy count and flags.
// Optional CMN_FIFO_VR_STAT_EN adds max_level (high-water mark) and drop_cnt (refused-push cycles).
module cmn_fifo_vr #(
  parameter int DW       = 32,
  parameter int AW       = 3,
  parameter int AF_LEVEL = (1 << AW) - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   count,
  output logic          almost_full,
  output logic          almost_empty
`ifdef CMN_FIFO_VR_STAT_EN
  ,
  output logic [AW:0]   max_level,
  output logic [15:0]   drop_cnt
`endif
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovld_q, ovld_d;
  logic [DW-1:0] odata_q, odata_d;
  logic          rdy_q, af_q, ae_q;
  logic          push, pop, mem_empty, mem_we;

  assign push      = in_valid & rdy_q;
  assign pop       = ovld_q & out_ready;
  // The array never fills completely, so equal pointers always mean empty.
  assign mem_empty = (rptr_q == wptr_q);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    ovld_d  = ovld_q;
    odata_d = odata_q;
    mem_we  = 1'b0;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovld_d = 1'b0;
    end else begin
      if (pop) begin
        if (!mem_empty) begin
          odata_d = mem[rptr_q];
          rptr_d  = rptr_q + AW'(1);
        end else if (push) begin
          odata_d = in_data;
        end else begin
          ovld_d = 1'b0;
        end
      end
      // A push bypasses the array whenever the output stage is (or is becoming) free.
      if (push) begin
        if (!ovld_q) begin
          odata_d = in_data;
          ovld_d  = 1'b1;
        end else if (!(pop && mem_empty)) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + AW'(1);
        end
      end
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovld_q  <= 1'b0;
      odata_q <= '0;
      rdy_q   <= 1'b1;
      af_q    <= (AF_LEVEL <= 0);
      ae_q    <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovld_q  <= ovld_d;
      odata_q <= odata_d;
      rdy_q   <= (cnt_d < DEPTH_C);
      af_q    <= (cnt_d >= AF_C);
      ae_q    <= (cnt_d <= AE_C);
    end
  end

  assign in_ready     = rdy_q;
  assign out_valid    = ovld_q;
  assign out_data     = odata_q;
  assign count        = cnt_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

`ifdef CMN_FIFO_VR_STAT_EN
  logic [AW:0] max_q;
  logic [15:0] drop_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      max_q  <= '0;
      drop_q <= '0;
    end else begin
      if (cnt_d > max_q) max_q <= cnt_d;
      if (in_valid && !rdy_q && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  assign max_level = max_q;
  assign drop_cnt  = drop_q;
`endif

endmodule

// File: tb/tb_cmn_fifo_vr.sv
// Scoreboard bench for cmn_fifo_vr: accepted pushes are queued, a negedge monitor checks every pop.
module tb_cmn_fifo_vr;
  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rstn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [AW:0]   count;
  logic          almost_full, almost_empty;
`ifdef CMN_FIFO_VR_STAT_EN
  logic [AW:0]   max_level;
  logic [15:0]   drop_cnt;
`endif

  cmn_fifo_vr #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
`ifdef CMN_FIFO_VR_STAT_EN
    , .max_level(max_level), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  int            exp_drop = 0;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Inputs are applied 1ns after a rising edge; the expected word is queued when the push will be accepted.
  task automatic drive(input bit iv, input logic [31:0] d, input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    if (iv && !in_ready) exp_drop++;
    if (fl) sb.delete();
    else if (iv && in_ready) sb.push_back(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstn && out_valid && out_ready && !flush) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got %0h want nothing", out_data);
      end else begin
        mon_exp = sb.pop_front();
        if (out_data !== mon_exp) begin
          bad++;
          $display("FAIL pop_data: got %0h want %0h", out_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    drive(0, 0, 0, 0);
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_almost_empty", 32'(almost_empty), 1);
    chk("rst_almost_full", 32'(almost_full), 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Fill to full with the consumer stalled.
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h10 + 32'(i), 0, 0);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_almost_full", 32'(almost_full), 32'(i + 1 >= 7));
      chk("fill_almost_empty", 32'(almost_empty), 32'(i + 1 <= 1));
    end
    chk("full_in_ready", 32'(in_ready), 0);
    drive(1, 32'hFF, 0, 0);
    tick();
    chk("refused_count", 32'(count), 8);
    chk("stall_out_data", out_data, 32'h10);

    // Drain at one word per cycle.
    drive(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain_count", 32'(count), 32'(7 - i));
    end
    chk("drained_out_valid", 32'(out_valid), 0);
    drive(0, 0, 0, 0);
    tick();

    // Streaming at count=1: each new word lands straight in the output stage.
    drive(1, 32'h100, 0, 0);
    tick();
    chk("stream1_prefill", 32'(count), 1);
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h101 + 32'(i), 1, 0);
      tick();
      chk("stream1_count", 32'(count), 1);
      chk("stream1_out_data", out_data, 32'h101 + 32'(i));
    end
    // Streaming at count=4 exercises the array with pointer wrap.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h180 + 32'(i), 0, 0);
      tick();
    end
    chk("stream4_prefill", 32'(count), 4);
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h1A0 + 32'(i), 1, 0);
      tick();
      chk("stream4_count", 32'(count), 4);
    end
    drive(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("stream_drained", 32'(count), 0);

    // Flush with a simultaneous push and pop.
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h200 + 32'(i), 0, 0);
      tick();
    end
    chk("preflush_count", 32'(count), 5);
    drive(1, 32'h2FF, 1, 1);
    tick();
    chk("flush_count", 32'(count), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    chk("flush_almost_empty", 32'(almost_empty), 1);
    drive(0, 0, 1, 0);
    tick();
    tick();
    chk("postflush_out_valid", 32'(out_valid), 0);
    drive(1, 32'h300, 1, 0);
    tick();
    chk("postflush_push_valid", 32'(out_valid), 1);
    chk("postflush_push_data", out_data, 32'h300);
    drive(0, 0, 1, 0);
    tick();
    chk("postflush_empty", 32'(out_valid), 0);

`ifdef CMN_FIFO_VR_STAT_EN
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h400 + 32'(i), 0, 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h4FF, 0, 0);
      tick();
    end
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    tick();
    chk("stat_flush_count", 32'(count), 0);
    chk("stat_max_level", 32'(max_level), 8);
    chk("stat_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
`endif

    chk("sb_empty", 32'(sb.size()), 0);

    // Asynchronous reset mid-operation, away from any clock edge.
    drive(1, 32'h500, 0, 0);
    tick();
    tick();
    drive(0, 0, 0, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_out_valid", 32'(out_valid), 0);
    chk("async_rst_in_ready", 32'(in_ready), 1);
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
